// File: rtl/panel_jam_seq_pkg.sv
// altair_pkg: opcodes, sequencer states and panel commands shared by the panel jam sequencer.
package altair_pkg;

    localparam logic [7:0] JMP_OP = 8'hC3;
    localparam logic [7:0] NOP_OP = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_J_OP,
        ST_J_LO,
        ST_J_HI,
        ST_J_NOP,
        ST_W_SYNC,
        ST_DEP
    } panel_state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_EXAM,
        CMD_EXNX,
        CMD_DEP,
        CMD_DPNX,
        CMD_RST
    } panel_cmd_t;

    // RESET outranks everything, then the deposit family, then examine.
    function automatic panel_cmd_t pick_cmd(input logic rst_p, input logic dpnx_p,
                                            input logic dep_p, input logic exnx_p,
                                            input logic exam_p);
        return rst_p  ? CMD_RST  :
               dpnx_p ? CMD_DPNX :
               dep_p  ? CMD_DEP  :
               exnx_p ? CMD_EXNX :
               exam_p ? CMD_EXAM : CMD_NONE;
    endfunction

endpackage

// File: rtl/panel_jam_seq_edge_rise.sv
// edge_rise: registered rising-edge detector; o_rise pulses one clk after i_d goes high.
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic r_prev;
    logic r_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_prev <= i_d;
            r_rise <= i_d & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/panel_jam_seq.sv
// panel_jam_seq: front-panel sequencer jamming opcodes onto the CPU read path and strobing deposits.
// Define PANEL_TIMEOUT_EN to abort stalled sequences after TIMEOUT_CYC cycles and flag err.
module panel_jam_seq
    import altair_pkg::*;
#(
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pause_sw,
    input  logic       exam_p,
    input  logic       exnx_p,
    input  logic       dep_p,
    input  logic       dpnx_p,
    input  logic       rst_p,
    input  logic [7:0] lo_sw,
    input  logic [7:0] hi_sw,
    input  logic       cpu_dbin,
    input  logic       cpu_sync,
    output logic       jam_act,
    output logic [7:0] jam_data,
    output logic       cpu_run,
    output logic       dep_we,
    output logic [7:0] dep_data,
    output logic       busy,
    output logic       err
);

`ifdef PANEL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    panel_state_t r_state;
    logic         r_jam_act;
    logic [7:0]   r_jam_data;
    logic         r_cpu_run;
    logic         r_dep_we;
    logic [7:0]   r_dep_data;
    logic         r_err;
    logic [7:0]   r_lo;
    logic [7:0]   r_hi;
    logic         r_is_dpnx;
    logic [TW-1:0] r_tmo;

    logic         w_dbin_rise;
    logic         w_sync_rise;
    logic         w_consume;
    logic         w_wait;
    logic         w_tmo;
    panel_cmd_t   w_cmd;

    edge_rise u_dbin_edge (.clk(clk), .rst_n(rst_n), .i_d(cpu_dbin), .o_rise(w_dbin_rise));
    edge_rise u_sync_edge (.clk(clk), .rst_n(rst_n), .i_d(cpu_sync), .o_rise(w_sync_rise));

    assign w_cmd     = (pause_sw && r_state == ST_IDLE) ?
                       pick_cmd(rst_p, dpnx_p, dep_p, exnx_p, exam_p) : CMD_NONE;
    assign w_consume = w_dbin_rise & r_jam_act;
    assign w_wait    = r_state inside {ST_J_OP, ST_J_LO, ST_J_HI, ST_J_NOP, ST_W_SYNC};
    assign w_tmo     = TMO_EN && w_wait && (r_tmo == TW'(TIMEOUT_CYC - 1));

    // With the timeout disabled the counter is held at zero and drops out in synthesis.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tmo <= '0;
        else if (!TMO_EN || !w_wait || w_consume || w_tmo)
            r_tmo <= '0;
        else
            r_tmo <= r_tmo + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_jam_act  <= 1'b0;
            r_jam_data <= 8'h00;
            r_cpu_run  <= 1'b0;
            r_dep_we   <= 1'b0;
            r_dep_data <= 8'h00;
            r_err      <= 1'b0;
            r_lo       <= 8'h00;
            r_hi       <= 8'h00;
            r_is_dpnx  <= 1'b0;
        end else begin
            r_dep_we <= 1'b0;
            if (w_tmo) begin
                r_state    <= ST_IDLE;
                r_jam_act  <= 1'b0;
                r_jam_data <= 8'h00;
                r_cpu_run  <= 1'b0;
                r_err      <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_cmd != CMD_NONE) begin
                            r_err     <= 1'b0;
                            r_is_dpnx <= (w_cmd == CMD_DPNX);
                            r_lo      <= (w_cmd == CMD_RST) ? 8'h00 : lo_sw;
                            r_hi      <= (w_cmd == CMD_RST) ? 8'h00 : hi_sw;
                            if (w_cmd == CMD_EXAM || w_cmd == CMD_RST) begin
                                r_state    <= ST_J_OP;
                                r_jam_act  <= 1'b1;
                                r_cpu_run  <= 1'b1;
                                r_jam_data <= JMP_OP;
                            end else if (w_cmd == CMD_EXNX || w_cmd == CMD_DPNX) begin
                                r_state    <= ST_J_NOP;
                                r_jam_act  <= 1'b1;
                                r_cpu_run  <= 1'b1;
                                r_jam_data <= NOP_OP;
                            end else begin
                                r_state    <= ST_DEP;
                                r_dep_we   <= 1'b1;
                                r_dep_data <= lo_sw;
                            end
                        end
                    end
                    ST_J_OP: begin
                        if (w_consume) begin
                            r_state    <= ST_J_LO;
                            r_jam_data <= r_lo;
                        end
                    end
                    ST_J_LO: begin
                        if (w_consume) begin
                            r_state    <= ST_J_HI;
                            r_jam_data <= r_hi;
                        end
                    end
                    ST_J_HI, ST_J_NOP: begin
                        // DEPOSIT NEXT keeps the CPU running until it fetches from the next address.
                        if (w_consume) begin
                            r_state    <= (r_state == ST_J_NOP && r_is_dpnx) ? ST_W_SYNC : ST_IDLE;
                            r_cpu_run  <= (r_state == ST_J_NOP && r_is_dpnx);
                            r_jam_act  <= 1'b0;
                            r_jam_data <= 8'h00;
                        end
                    end
                    ST_W_SYNC: begin
                        if (w_sync_rise) begin
                            r_state    <= ST_DEP;
                            r_cpu_run  <= 1'b0;
                            r_dep_we   <= 1'b1;
                            r_dep_data <= r_lo;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign jam_act  = r_jam_act;
    assign jam_data = r_jam_data;
    assign cpu_run  = r_cpu_run;
    assign dep_we   = r_dep_we;
    assign dep_data = r_dep_data;
    assign busy     = (r_state != ST_IDLE);
    assign err      = r_err;

endmodule
